vga_timing_ctrl: RTL and testbench

//  Programmable VGA raster controller: runs h/v counters, emits hsync/vsync and a pixel-clock-aligned
//  RGB stream, and pulls pixels from an upstream framebuffer/generator via valid/ready. Sits between the

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_pix_if.sv | 9 +
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_timing_ctrl.sv | 148 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster controller: default timing,
// config register addresses and the run-control state encoding.
package vga_pkg;

    // Default 640x480@60 timing, applied at reset
    localparam int DEF_HS   = 96;
    localparam int DEF_HBP  = 48;
    localparam int DEF_HACT = 640;
    localparam int DEF_HFP  = 16;
    localparam int DEF_VS   = 2;
    localparam int DEF_VBP  = 33;
    localparam int DEF_VACT = 480;
    localparam int DEF_VFP  = 10;

    // Config register map
    localparam logic [2:0] CFG_HS   = 3'd0;
    localparam logic [2:0] CFG_HBP  = 3'd1;
    localparam logic [2:0] CFG_HACT = 3'd2;
    localparam logic [2:0] CFG_HFP  = 3'd3;
    localparam logic [2:0] CFG_VS   = 3'd4;
    localparam logic [2:0] CFG_VBP  = 3'd5;
    localparam logic [2:0] CFG_VACT = 3'd6;
    localparam logic [2:0] CFG_VFP  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

endpackage

// File: rtl/vga_pix_if.sv
// Upstream pixel stream: valid/ready handshake carrying one {r,g,b} pixel.
interface vga_pix_if;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic        pix_ready;

    modport master (output pix_valid, output pix_rgb, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_rgb, output pix_ready);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis (H or V): position counter plus SYNC/BP/ACTIVE/FP phase decode.
module vga_axis_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [CW-1:0] seg_sync,
    input  logic [CW-1:0] seg_bp,
    input  logic [CW-1:0] seg_act,
    input  logic [CW-1:0] seg_fp,
    output logic [CW+1:0] cnt,
    output logic          in_sync,
    output logic          in_active,
    output logic          at_last
);
    localparam int TW = CW + 2;

    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] end_sync, end_bp, end_act, total;

    // Segment boundaries; two extra bits keep the 4-term sum from overflowing
    always_comb begin
        end_sync = TW'(seg_sync);
        end_bp   = end_sync + TW'(seg_bp);
        end_act  = end_bp + TW'(seg_act);
        total    = end_act + TW'(seg_fp);
    end

    assign at_last   = (cnt_q == total - TW'(1));
    assign in_sync   = (cnt_q < end_sync);
    assign in_active = (cnt_q >= end_bp) && (cnt_q < end_act);
    assign cnt       = cnt_q;

    // Next position: held at 0 when stopped, wraps after the last cycle
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = at_last ? '0 : cnt_q + TW'(1);
        end
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA raster controller: timing register file with frame-boundary
// shadow copy, run/stop FSM, H/V counters, registered RGB/sync outputs.
module vga_timing_ctrl #(
    parameter int CW       = 16,
    parameter int DEF_HS   = vga_pkg::DEF_HS,
    parameter int DEF_HBP  = vga_pkg::DEF_HBP,
    parameter int DEF_HACT = vga_pkg::DEF_HACT,
    parameter int DEF_HFP  = vga_pkg::DEF_HFP,
    parameter int DEF_VS   = vga_pkg::DEF_VS,
    parameter int DEF_VBP  = vga_pkg::DEF_VBP,
    parameter int DEF_VACT = vga_pkg::DEF_VACT,
    parameter int DEF_VFP  = vga_pkg::DEF_VFP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    vga_pix_if.slave      pix,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          underflow,
    input  logic          underflow_clr
);
    import vga_pkg::*;

    localparam logic [7:0][CW-1:0] DEF_TAB = {
        CW'(DEF_VFP), CW'(DEF_VACT), CW'(DEF_VBP), CW'(DEF_VS),
        CW'(DEF_HFP), CW'(DEF_HACT), CW'(DEF_HBP), CW'(DEF_HS)
    };

    state_e              state_q, state_d;
    logic [7:0][CW-1:0]  pend_q, pend_d, act_q, act_d;
    logic [23:0]         rgb_q, rgb_d;
    logic                hsync_q, hsync_d, vsync_q, vsync_d;
    logic                fs_q, fs_d, uf_q, uf_d;

    logic [CW+1:0]       h_cnt, v_cnt;
    logic                h_sync, h_act, h_last;
    logic                v_sync, v_act, v_last;
    logic                running, frame_last;

    assign running    = (state_q != ST_IDLE);
    assign frame_last = running && h_last && v_last;

    vga_axis_counter #(.CW(CW)) u_hcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!running),
        .advance  (running),
        .seg_sync (act_q[CFG_HS]),
        .seg_bp   (act_q[CFG_HBP]),
        .seg_act  (act_q[CFG_HACT]),
        .seg_fp   (act_q[CFG_HFP]),
        .cnt      (h_cnt),
        .in_sync  (h_sync),
        .in_active(h_act),
        .at_last  (h_last)
    );

    vga_axis_counter #(.CW(CW)) u_vcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!running),
        .advance  (running && h_last),
        .seg_sync (act_q[CFG_VS]),
        .seg_bp   (act_q[CFG_VBP]),
        .seg_act  (act_q[CFG_VACT]),
        .seg_fp   (act_q[CFG_VFP]),
        .cnt      (v_cnt),
        .in_sync  (v_sync),
        .in_active(v_act),
        .at_last  (v_last)
    );

    assign pix.pix_ready = running && h_act && v_act;

    // Register file: writes land in pending (0 clamped to 1); active follows only between frames
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (cfg_we) begin
            pend_d[cfg_addr] = (cfg_wdata == '0) ? CW'(1) : cfg_wdata;
        end
        if (state_q == ST_IDLE || frame_last) begin
            act_d = pend_q;
        end
    end

    // Run control: stopping always lets the current frame finish
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = frame_last ? ST_IDLE : ST_STOP;
            ST_STOP: if (enable) state_d = ST_RUN;
                     else if (frame_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage: colour, syncs and frame marker from this cycle's counter state
    always_comb begin
        rgb_d   = '0;
        if (pix.pix_ready && pix.pix_valid) rgb_d = pix.pix_rgb;
        hsync_d = !(running && h_sync);
        vsync_d = !(running && v_sync);
        fs_d    = running && (h_cnt == '0) && (v_cnt == '0);
        // A new underflow outranks a concurrent clear
        uf_d    = (pix.pix_ready && !pix.pix_valid) || (uf_q && !underflow_clr);
    end

    // State, register file and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            // NOTE: the small timing register file is reset on purpose; its defaults define the raster
            pend_q  <= DEF_TAB;
            act_q   <= DEF_TAB;
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

    assign {r, g, b}   = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl with a cycle reference model feeding a scoreboard.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          underflow_clr = 1'b0;
    logic [7:0]    r, g, b;
    logic          hsync, vsync, frame_start, underflow;

    vga_pix_if pix ();

    vga_timing_ctrl #(.CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .pix          (pix),
        .r            (r),
        .g            (g),
        .b            (b),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_start  (frame_start),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        uf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // Reference model state (0 idle, 1 run, 2 stop)
    int m_state, m_h, m_v;
    int m_act[8];
    int m_pend[8];
    logic m_uf;
    int def_tab[8] = '{96, 48, 640, 16, 2, 33, 480, 10};

    // Observed-stream statistics
    int cyc = 0, acc = 0, acc_fs = 0, fs_cnt = 0, fs_cyc = 0;
    int fs_period = 0, fs_pix = 0;
    int hs_run = 0, hs_low_last = 0, vs_run = 0, vs_low_last = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_ready();
        int hb, vb;
        hb = m_act[0] + m_act[1];
        vb = m_act[4] + m_act[5];
        return (m_state != 0) && (m_h >= hb) && (m_h < hb + m_act[2]) &&
               (m_v >= vb) && (m_v < vb + m_act[6]);
    endfunction

    task automatic model_reset();
        m_state = 0; m_h = 0; m_v = 0; m_uf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_act[i]  = def_tab[i];
            m_pend[i] = def_tab[i];
        end
        sb.delete();
    endtask

    // One clock: entered and left 1 time unit after a rising edge
    task automatic tick();
        logic rdy, run, last, took;
        exp_t e;
        int htot, vtot, st;
        #1;
        rdy  = model_ready();
        run  = (m_state != 0);
        took = rdy && pix.pix_valid;
        check("pix_ready", {31'd0, pix.pix_ready}, {31'd0, rdy});
        if (pix.pix_ready && pix.pix_valid) acc++;
        e.rgb = took ? pix.pix_rgb : 24'h0;
        e.hs  = run ? (m_h >= m_act[0]) : 1'b1;
        e.vs  = run ? (m_v >= m_act[4]) : 1'b1;
        e.fs  = run && (m_h == 0) && (m_v == 0);
        e.uf  = (rdy && !pix.pix_valid) || (m_uf && !underflow_clr);
        sb.push_back(e);
        htot = m_act[0] + m_act[1] + m_act[2] + m_act[3];
        vtot = m_act[4] + m_act[5] + m_act[6] + m_act[7];
        last = run && (m_h == htot - 1) && (m_v == vtot - 1);
        case (m_state)
            0:       st = enable ? 1 : 0;
            default: st = enable ? 1 : (last ? 0 : 2);
        endcase
        if (m_state == 0 || last)
            for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
        if (cfg_we) m_pend[cfg_addr] = (cfg_wdata == 0) ? 1 : int'(cfg_wdata);
        if (!run) begin
            m_h = 0; m_v = 0;
        end else if (m_h == htot - 1) begin
            m_h = 0;
            m_v = (m_v == vtot - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        m_uf = e.uf;
        m_state = st;

        @(posedge clk);
        #1;
        cyc++;
        if (took) pix.pix_rgb = pix.pix_rgb + 24'd1;
        e = sb.pop_front();
        check("rgb", {8'd0, r, g, b}, {8'd0, e.rgb});
        check("hsync", {31'd0, hsync}, {31'd0, e.hs});
        check("vsync", {31'd0, vsync}, {31'd0, e.vs});
        check("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
        check("underflow", {31'd0, underflow}, {31'd0, e.uf});
        if (frame_start === 1'b1) begin
            fs_period = cyc - fs_cyc; fs_cyc = cyc;
            fs_pix = acc - acc_fs; acc_fs = acc;
            fs_cnt++;
        end
        if (hsync === 1'b0) hs_run++;
        else if (hs_run != 0) begin hs_low_last = hs_run; hs_run = 0; end
        if (vsync === 1'b0) vs_run++;
        else if (vs_run != 0) begin vs_low_last = vs_run; vs_run = 0; end
    endtask

    task automatic cfg_write(logic [2:0] a, logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_fs(int max_cyc);
        int start;
        start = fs_cnt;
        for (int i = 0; i < max_cyc && fs_cnt == start; i++) tick();
        check("wait_frame_start", {31'd0, fs_cnt != start}, 32'd1);
    endtask

    task automatic wait_line(int v, int max_cyc);
        for (int i = 0; i < max_cyc && !(m_v == v && m_h == 0); i++) tick();
        check("wait_line", {31'd0, (m_v == v && m_h == 0)}, 32'd1);
    endtask

    task automatic wait_ready(int max_cyc);
        for (int i = 0; i < max_cyc && !model_ready(); i++) tick();
        check("wait_ready", {31'd0, model_ready()}, 32'd1);
    endtask

    initial begin
        int fs_before;
        pix.pix_valid = 1'b1;
        pix.pix_rgb   = 24'h000001;
        model_reset();

        // Reset state
        #12;
        check("rst_hsync", {31'd0, hsync}, 32'd1);
        check("rst_vsync", {31'd0, vsync}, 32'd1);
        check("rst_rgb", {8'd0, r, g, b}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_uf", {31'd0, underflow}, 32'd0);
        check("rst_ready", {31'd0, pix.pix_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();

        // Small raster: H 2/2/4/2, V 1/1/3/1
        cfg_write(CFG_HS, 2);  cfg_write(CFG_HBP, 2);
        cfg_write(CFG_HACT, 4); cfg_write(CFG_HFP, 2);
        cfg_write(CFG_VS, 1);  cfg_write(CFG_VBP, 1);
        cfg_write(CFG_VACT, 3); cfg_write(CFG_VFP, 1);
        tick();

        // Basic raster
        enable = 1'b1;
        wait_fs(20);
        wait_fs(80);
        check("frame_period", fs_period, 32'd60);
        check("frame_pixels", fs_pix, 32'd12);
        check("hsync_low_len", hs_low_last, 32'd2);
        check("vsync_low_len", vs_low_last, 32'd10);

        // Mid-frame HACT change applies from the next frame
        wait_line(2, 80);
        cfg_write(CFG_HACT, 6);
        wait_fs(80);
        check("frame_period_old", fs_period, 32'd60);
        wait_fs(100);
        check("frame_period_new", fs_period, 32'd72);
        check("frame_pixels_new", fs_pix, 32'd18);

        // Underflow on the second active slot, sticky, set beats clear
        wait_ready(100);
        tick();
        wait_ready(100);
        pix.pix_valid = 1'b0;
        tick();
        pix.pix_valid = 1'b1;
        check("uf_rgb_zero", {8'd0, r, g, b}, 32'd0);
        check("uf_set", {31'd0, underflow}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("uf_sticky", {31'd0, underflow}, 32'd1);
        wait_ready(100);
        pix.pix_valid = 1'b0; underflow_clr = 1'b1;
        tick();
        pix.pix_valid = 1'b1; underflow_clr = 1'b0;
        check("uf_set_wins", {31'd0, underflow}, 32'd1);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("uf_cleared", {31'd0, underflow}, 32'd0);

        // Stop at end of frame, then restart
        cfg_write(CFG_HACT, 4);
        wait_fs(100);
        wait_line(1, 80);
        enable = 1'b0;
        for (int i = 0; i < 100 && m_state != 0; i++) tick();
        check("stop_reaches_idle", {31'd0, m_state == 0}, 32'd1);
        check("stop_frame_period", cyc - fs_cyc, 32'd59);
        fs_before = fs_cnt;
        for (int i = 0; i < 15; i++) tick();
        check("idle_no_fs", fs_cnt, fs_before);
        check("idle_hsync", {31'd0, hsync}, 32'd1);
        check("idle_vsync", {31'd0, vsync}, 32'd1);
        check("idle_ready", {31'd0, pix.pix_ready}, 32'd0);
        enable = 1'b1;
        tick(); tick();
        check("restart_fs", {31'd0, frame_start}, 32'd1);

        // VS written as 0 behaves as 1 line
        cfg_write(CFG_VS, 0);
        wait_fs(100);
        wait_fs(100);
        check("vs0_low_len", vs_low_last, 32'd10);
        check("vs0_period", fs_period, 32'd60);

        // Reset mid-frame
        wait_line(3, 80);
        wait_ready(20);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_hsync", {31'd0, hsync}, 32'd1);
        check("midrst_vsync", {31'd0, vsync}, 32'd1);
        check("midrst_rgb", {8'd0, r, g, b}, 32'd0);
        check("midrst_ready", {31'd0, pix.pix_ready}, 32'd0);
        check("midrst_fs", {31'd0, frame_start}, 32'd0);
        model_reset();
        enable = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_ready", {31'd0, pix.pix_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
